// File: rtl/p0013_pkg.sv
// p0013_pkg: shared definitions for the Project Euler #13 engine.
//   state_t      : FSM states SUM -> EMIT -> CONV -> DONE | ERR
//   BCD_MAX      : largest legal digit value held in the digit ROM
//   DIGIT_W      : width of one BCD digit
//   RESULT_W     : width of the reported binary result
//   DEF_*        : default parameter values for the top
//   DEF_ROM_INIT : default digit image, one 4-bit digit per address, written
//                  as one hex literal per addend so the BCD digits read exactly
//                  like the decimal numbers; address 0 is the top nibble.
package p0013_pkg;

    typedef enum logic [2:0] {
        ST_SUM,
        ST_EMIT,
        ST_CONV,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [3:0]  BCD_MAX      = 4'd9;
    localparam int unsigned DIGIT_W      = 4;
    localparam int unsigned RESULT_W     = 40;
    localparam int unsigned DEF_N_NUMS   = 100;
    localparam int unsigned DEF_N_DIGITS = 50;
    localparam int unsigned DEF_N_OUT    = 10;

    localparam logic [DEF_N_NUMS*DEF_N_DIGITS*DIGIT_W-1:0] DEF_ROM_INIT = {
        200'h37107287533902102798797998220837590246510135740250,
        200'h46376937677490009712648124896970078050417018260538,
        200'h74324986199524741059474233309513058123726617309629,
        200'h91942213363574161572522430563301811072406154908250,
        200'h23067588207539346171171980310421047513778063246676,
        200'h89261670696623633820136378418383684178734361726757,
        200'h28112879812849979408065481931592621691275889832738,
        200'h44274228917432520321923589422876796487670272189318,
        200'h47451445736001306439091167216856844588711603153276,
        200'h70386486105843025439939619828917593665686757934951,
        200'h62176457141856560629502157223196586755079324193331,
        200'h64906352462741904929101432445813822663347944758178,
        200'h92575867718337217661963751590579239728245598838407,
        200'h58203565325359399008402633568948830189458628227828,
        200'h80181199384826282014278194139940567587151170094390,
        200'h35398664372827112653829987240784473053190104293586,
        200'h86515506006295864861532075273371959191420517255829,
        200'h71693888707715466499115593487603532921714970056938,
        200'h54370070576826684624621495650076471787294438377604,
        200'h53282654108756828443191190634694037855217779295145,
        200'h36123272525000296071075082563815656710885258350721,
        200'h45876576172410976447339110607218265236877223636045,
        200'h17423706905851860660448207621209813287860733969412,
        200'h81142660418086830619328460811191061556940512689692,
        200'h51934325451728388641918047049293215058642563049483,
        200'h62467221648435076201727918039944693004732956340691,
        200'h15732444386908125794514089057706229429197107928209,
        200'h55037687525678773091862540744969844508330393682126,
        200'h18336384825330154686196124348767681297534375946515,
        200'h80386287592878490201521685554828717201219257766954,
        200'h78182833757993103614740356856449095527097864797581,
        200'h16726320100436897842553539920931837441497806860984,
        200'h48403098129077791799088218795327364475675590848030,
        200'h87086987551392711854517078544161852424320693150332,
        200'h59959406895756536782107074926966537676326235447210,
        200'h69793950679652694742597709739166693763042633987085,
        200'h41052684708299085211399427365734116182760315001271,
        200'h65378607361501080857009149939512557028198746004375,
        200'h35829035317434717326932123578154982629742552737307,
        200'h94953759765105305946966067683156574377167401875275,
        200'h88902802571733229619176668713819931811048770190271,
        200'h25267680276078003013678680992525463401061632866526,
        200'h36270218540497705585629946580636237993140746255962,
        200'h24074486908231174977792365466257246923322810917141,
        200'h91430288197103288597806669760892938638285025333403,
        200'h34413065578016127815921815005561868836468420090470,
        200'h23053081172816430487623791969842487255036638784583,
        200'h11487696932154902810424020138335124462181441773470,
        200'h63783299490636259666498587618221225225512486764533,
        200'h67720186971698544312419572409913959008952310058822,
        200'h95548255300263520781532296796249481641953868218774,
        200'h76085327132285723110424803456124867697064507995236,
        200'h37774242535411291684276865538926205024910326572967,
        200'h23701913275725675285653248258265463092207058596522,
        200'h29798860272258331913126375147341994889534765745501,
        200'h18495701454879288984856827726077713721403798879715,
        200'h38298203783031473527721580348144513491373226651381,
        200'h34829543829199918180278916522431027392251122869539,
        200'h40957953066405232632538044100059654939159879593635,
        200'h29746152185502371307642255121183693803580388584903,
        200'h41698116222072977186158236678424689157993532961922,
        200'h62467957194401269043877107275048102390895523597457,
        200'h23189706772547915061505504953922979530901129967519,
        200'h86188088225875314529584099251203829009407770775672,
        200'h11306739708304724483816533873502340845647058077308,
        200'h82959174767140363198008187129011875491310547126581,
        200'h97623331044818386269515456334926366572897563400500,
        200'h42846280183517070527831839425882145521227251250327,
        200'h55121603546981200581762165212827652751691296897789,
        200'h32238195734329339946437501907836945765883352399886,
        200'h75506164965184775180738168837861091527357929701337,
        200'h62177842752192623401942399639168044983993173312731,
        200'h32924185707147349566916674687634660915035914677504,
        200'h99518671430235219628894890102423325116913619626622,
        200'h73267460800591547471830798392868535206946944540724,
        200'h76841822524674417161514036427982273348055556214818,
        200'h97142617910342598647204516893989422179826088076852,
        200'h87783646182799346313767754307809363333018982642090,
        200'h10848802521674670883215120185883543223812876952786,
        200'h71329612474782464538636993009049310363619763878039,
        200'h62184073572399794223406235393808339651327408011116,
        200'h66627891981488087797941876876144230030984490851411,
        200'h60661826293682836764744779239180335110989069790714,
        200'h85786944089552990653640447425576083659976645795096,
        200'h66024396409905389607120198219976047599490197230297,
        200'h64913982680032973156037120041377903785566085089252,
        200'h16730939319872750275468906903707539413042652315011,
        200'h94809377245048795150954100921645863754710598436791,
        200'h78639167021187492431995700641917969777599028300699,
        200'h15368713711936614952811305876380278410754449733078,
        200'h40789923115535562561142322423255033685442488917353,
        200'h44889911501440648020369068063960672322193204149535,
        200'h41503128880339536053299340368006977710650566631954,
        200'h81234880673210146739058568557934581403627822703280,
        200'h82616570773948327592232845941706525094512325230608,
        200'h22918802058777319719839450180888072429661980811197,
        200'h77158542502016545090413245809786882778948721859617,
        200'h72107838435069186155435662884062257473692284509516,
        200'h20849603980134001723930671666823555245252804609722,
        200'h53503534226472524250874054075591789781264330331690
    };

endpackage

// File: rtl/p0013_if.sv
// p0013_if: result bundle of the Euler #13 engine.
//   result : binary value of the leading digits of the sum (zero-extended)
//   done   : result valid, sticky until reset
//   error  : non-BCD digit seen in the ROM, sticky until reset
// master modport drives the bundle (engine), slave observes it.
interface p0013_if;
    import p0013_pkg::*;

    logic [RESULT_W-1:0] result;
    logic                done;
    logic                error;

    modport master (output result, output done, output error);
    modport slave  (input  result, input  done, input  error);

endinterface

// File: rtl/p0013_digit_rom.sv
// p0013_digit_rom: synchronous-read digit ROM, one BCD digit per word.
//   clk    : rising-edge clock
//   i_addr : word address, num*N_DIGITS + col
//   o_data : digit at the address presented on the previous edge
// INIT holds the whole image as one vector in address order, address 0 in
// the most significant nibble.
module p0013_digit_rom
    import p0013_pkg::*;
#(
    parameter int unsigned             DEPTH = 6,
    parameter int unsigned             AW    = 3,
    parameter logic [DEPTH*DIGIT_W-1:0] INIT  = '0
) (
    input  logic               clk,
    input  logic [AW-1:0]      i_addr,
    output logic [DIGIT_W-1:0] o_data
);

    localparam int unsigned BW = $clog2(DEPTH * DIGIT_W);

    logic [BW-1:0]      w_bit;
    logic [DIGIT_W-1:0] r_data;

    assign w_bit = BW'((DEPTH - 1 - 32'(i_addr)) * DIGIT_W);

    always_ff @(posedge clk) begin
        r_data <= INIT[w_bit +: DIGIT_W];
    end

    assign o_data = r_data;

endmodule

// File: rtl/p0013.sv
// p0013: self-starting Project Euler #13 engine.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset; the run starts on release
//   bus   : master side of p0013_if (result / done / error)
// Columns are summed right to left, one ROM digit per cycle, into a digit
// buffer plus final carry. The carry's decimal digits followed by the buffer
// form a digit stream whose first N_OUT digits are folded into a binary value.
module p0013
    import p0013_pkg::*;
#(
    parameter int unsigned N_NUMS   = DEF_N_NUMS,
    parameter int unsigned N_DIGITS = DEF_N_DIGITS,
    parameter int unsigned N_OUT    = DEF_N_OUT,
    parameter logic [N_NUMS*N_DIGITS*DIGIT_W-1:0] ROM_INIT = DEF_ROM_INIT
) (
    input  logic    clk,
    input  logic    rst_n,
    p0013_if.master bus
);

    localparam int unsigned DEPTH = N_NUMS * N_DIGITS;
    localparam int unsigned AW    = (DEPTH    > 1) ? $clog2(DEPTH)    : 1;
    localparam int unsigned NW    = (N_NUMS   > 1) ? $clog2(N_NUMS)   : 1;
    localparam int unsigned CW    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned OW    = (N_OUT    > 1) ? $clog2(N_OUT)    : 1;

    state_t r_state, w_next;

    // address issue side
    logic [NW-1:0] r_num;
    logic [CW-1:0] r_col;
    logic          r_issuing;
    logic [AW-1:0] w_addr;

    // tags travelling alongside the one-cycle ROM read
    logic          r_vld;
    logic          r_tag_last_num;
    logic          r_tag_last_col;
    logic [CW-1:0] r_tag_col;

    logic [DIGIT_W-1:0] w_rom_data;
    logic [9:0]         r_colsum, w_sum, w_quot;
    logic [3:0]         w_rem;
    logic               w_bad, w_sum_fin;
    logic [3:0]         r_dig [N_DIGITS];

    // carry split into leading stream digits
    logic [3:0] w_ct, w_co;

    // converter
    logic [1:0]          r_pre_n;
    logic [3:0]          r_pre0, r_pre1;
    logic [CW-1:0]       r_dptr;
    logic [OW-1:0]       r_ocnt;
    logic [RESULT_W-1:0] r_acc, w_acc_next, r_result;
    logic [3:0]          w_digit;
    logic                w_conv_last;
    logic                r_done;

    p0013_digit_rom #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .INIT  (ROM_INIT)
    ) u_rom (
        .clk    (clk),
        .i_addr (w_addr),
        .o_data (w_rom_data)
    );

    assign w_addr    = AW'(32'(r_num) * N_DIGITS + 32'(r_col));
    assign w_sum     = r_colsum + 10'(w_rom_data);
    assign w_quot    = w_sum / 10'd10;
    assign w_rem     = 4'(w_sum - w_quot * 10'd10);
    assign w_bad     = r_vld && (w_rom_data > BCD_MAX);
    assign w_sum_fin = r_vld && r_tag_last_num && r_tag_last_col && !w_bad;

    // carry after the last column is at most 99, so 7 bits suffice
    assign w_ct = 4'(r_colsum[6:0] / 7'd10);
    assign w_co = 4'(r_colsum[6:0] - 7'(w_ct) * 7'd10);

    always_comb begin
        w_digit = r_dig[r_dptr];
        if (r_pre_n != 2'd0) begin
            w_digit = r_pre0;
        end
    end

    assign w_acc_next  = (r_acc << 3) + (r_acc << 1) + RESULT_W'(w_digit);
    // stop after N_OUT digits, or earlier when the buffer is exhausted
    assign w_conv_last = (r_ocnt == OW'(N_OUT - 1)) ||
                         ((r_pre_n == 2'd0) && (r_dptr == CW'(N_DIGITS - 1)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_SUM;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_SUM: begin
                if (w_bad) begin
                    w_next = ST_ERR;
                end else if (w_sum_fin) begin
                    w_next = ST_EMIT;
                end
            end
            ST_EMIT: w_next = ST_CONV;
            ST_CONV: begin
                if (w_conv_last) begin
                    w_next = ST_DONE;
                end
            end
            default: w_next = r_state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_num          <= '0;
            r_col          <= CW'(N_DIGITS - 1);
            r_issuing      <= 1'b1;
            r_vld          <= 1'b0;
            r_tag_last_num <= 1'b0;
            r_tag_last_col <= 1'b0;
            r_tag_col      <= '0;
            r_colsum       <= '0;
            r_pre_n        <= '0;
            r_pre0         <= '0;
            r_pre1         <= '0;
            r_dptr         <= '0;
            r_ocnt         <= '0;
            r_acc          <= '0;
            r_result       <= '0;
            r_done         <= 1'b0;
            for (int unsigned i = 0; i < N_DIGITS; i++) begin
                r_dig[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_SUM: begin
                    r_vld <= r_issuing;
                    if (r_issuing) begin
                        r_tag_col      <= r_col;
                        r_tag_last_num <= (r_num == NW'(N_NUMS - 1));
                        r_tag_last_col <= (r_col == '0);
                        if (r_num == NW'(N_NUMS - 1)) begin
                            r_num <= '0;
                            if (r_col == '0) begin
                                r_issuing <= 1'b0;
                            end else begin
                                r_col <= r_col - 1'b1;
                            end
                        end else begin
                            r_num <= r_num + 1'b1;
                        end
                    end
                    // the column's quotient becomes the next column's carry-in
                    if (r_vld) begin
                        if (r_tag_last_num) begin
                            r_dig[r_tag_col] <= w_rem;
                            r_colsum         <= w_quot;
                        end else begin
                            r_colsum <= w_sum;
                        end
                    end
                end
                ST_EMIT: begin
                    r_acc  <= '0;
                    r_ocnt <= '0;
                    r_dptr <= '0;
                    r_pre1 <= w_co;
                    if (w_ct != 4'd0) begin
                        r_pre_n <= 2'd2;
                        r_pre0  <= w_ct;
                    end else if (w_co != 4'd0) begin
                        r_pre_n <= 2'd1;
                        r_pre0  <= w_co;
                    end else begin
                        r_pre_n <= 2'd0;
                    end
                end
                ST_CONV: begin
                    r_acc  <= w_acc_next;
                    r_ocnt <= r_ocnt + 1'b1;
                    if (r_pre_n != 2'd0) begin
                        r_pre_n <= r_pre_n - 2'd1;
                        r_pre0  <= r_pre1;
                    end else begin
                        r_dptr <= r_dptr + 1'b1;
                    end
                    if (w_conv_last) begin
                        r_result <= w_acc_next;
                        r_done   <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.result = r_result;
    assign bus.done   = r_done;
    assign bus.error  = (r_state == ST_ERR);

endmodule

// File: tb/tb_p0013.sv
module tb_p0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1_n = 1'b0;
    logic rsts_n = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int run_cyc = 0;

    localparam logic [39:0] EULER = 40'd5537376230;

    p0013_if bus1 ();
    p0013_if bus2 ();
    p0013_if bus3 ();
    p0013_if bus4 ();

    p0013 u_def (
        .clk   (clk),
        .rst_n (rst1_n),
        .bus   (bus1)
    );

    p0013 #(.N_NUMS(2), .N_DIGITS(3), .N_OUT(2), .ROM_INIT(24'h999999)) u_carry (
        .clk   (clk),
        .rst_n (rsts_n),
        .bus   (bus2)
    );

    p0013 #(.N_NUMS(2), .N_DIGITS(3), .N_OUT(4), .ROM_INIT(24'h123456)) u_short (
        .clk   (clk),
        .rst_n (rsts_n),
        .bus   (bus3)
    );

    p0013 #(.N_NUMS(2), .N_DIGITS(3), .N_OUT(2), .ROM_INIT(24'h12A456)) u_err (
        .clk   (clk),
        .rst_n (rsts_n),
        .bus   (bus4)
    );

    // cycles since the default instance last left reset
    always @(posedge clk) begin
        if (!rst1_n) run_cyc <= 0;
        else         run_cyc <= run_cyc + 1;
    end

    task automatic test_reset;
        rst1_n = 1'b0;
        rsts_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus1.result, bus1.done, bus1.error} !== 42'd0) begin
            n_bad++;
            $display("FAIL reset_def got %h/%b/%b need 0/0/0", bus1.result, bus1.done, bus1.error);
        end
        n_cmp++;
        if ({bus2.result, bus2.done, bus2.error} !== 42'd0) begin
            n_bad++;
            $display("FAIL reset_carry got %h/%b/%b need 0/0/0", bus2.result, bus2.done, bus2.error);
        end
        n_cmp++;
        if ({bus3.result, bus3.done, bus3.error} !== 42'd0) begin
            n_bad++;
            $display("FAIL reset_short got %h/%b/%b need 0/0/0", bus3.result, bus3.done, bus3.error);
        end
        n_cmp++;
        if ({bus4.result, bus4.done, bus4.error} !== 42'd0) begin
            n_bad++;
            $display("FAIL reset_err got %h/%b/%b need 0/0/0", bus4.result, bus4.done, bus4.error);
        end
        rst1_n = 1'b1;
        rsts_n = 1'b1;
    endtask

    task automatic test_carry_prefix;
        for (int i = 0; i < 200 && bus2.done !== 1'b1; i++) @(negedge clk);
        n_cmp++;
        if (bus2.done !== 1'b1) begin
            n_bad++;
            $display("FAIL carry_done timeout got done=%b need 1", bus2.done);
        end
        n_cmp++;
        if (bus2.result !== 40'd19) begin
            n_bad++;
            $display("FAIL carry_result got %0d need 19", bus2.result);
        end
        n_cmp++;
        if (bus2.error !== 1'b0) begin
            n_bad++;
            $display("FAIL carry_error got %b need 0", bus2.error);
        end
    endtask

    task automatic test_short_stream;
        for (int i = 0; i < 200 && bus3.done !== 1'b1; i++) @(negedge clk);
        n_cmp++;
        if (bus3.done !== 1'b1) begin
            n_bad++;
            $display("FAIL short_done timeout got done=%b need 1", bus3.done);
        end
        n_cmp++;
        if (bus3.result !== 40'd579) begin
            n_bad++;
            $display("FAIL short_result got %0d need 579", bus3.result);
        end
    endtask

    task automatic test_error;
        int errs;
        errs = 0;
        for (int i = 0; i < 200 && bus4.error !== 1'b1; i++) @(negedge clk);
        n_cmp++;
        if (bus4.error !== 1'b1) begin
            n_bad++;
            $display("FAIL err_seen timeout got error=%b need 1", bus4.error);
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus4.result, bus4.done, bus4.error} !== 42'd1) begin
                n_bad++;
                if (errs < 5) $display("FAIL err_hold cyc %0d got %h/%b/%b need 0/0/1", i, bus4.result, bus4.done, bus4.error);
                errs++;
            end
        end
    endtask

    task automatic test_default;
        for (int i = 0; i < 7000 && bus1.done !== 1'b1 && run_cyc <= 6000; i++) @(negedge clk);
        n_cmp++;
        if (bus1.done !== 1'b1) begin
            n_bad++;
            $display("FAIL def_done timeout got done=%b at cyc %0d need 1 by 6000", bus1.done, run_cyc);
        end
        n_cmp++;
        if (run_cyc < 5000 || run_cyc > 6000) begin
            n_bad++;
            $display("FAIL def_latency got %0d cycles need 5000..6000", run_cyc);
        end
        n_cmp++;
        if (bus1.result !== EULER) begin
            n_bad++;
            $display("FAIL def_result got %0d need %0d", bus1.result, EULER);
        end
        n_cmp++;
        if (bus1.error !== 1'b0) begin
            n_bad++;
            $display("FAIL def_error got %b need 0", bus1.error);
        end
    endtask

    task automatic test_hold;
        int errs;
        errs = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus1.result, bus1.done, bus1.error} !== {EULER, 2'b10}) begin
                n_bad++;
                if (errs < 5) $display("FAIL hold cyc %0d got %0d/%b/%b need %0d/1/0", i, bus1.result, bus1.done, bus1.error, EULER);
                errs++;
            end
        end
    endtask

    task automatic test_midrun_reset;
        rst1_n = 1'b0;
        repeat (2) @(negedge clk);
        rst1_n = 1'b1;
        for (int i = 0; i < 2100 && run_cyc < 2000; i++) @(negedge clk);
        n_cmp++;
        if (bus1.done !== 1'b0 || run_cyc != 2000) begin
            n_bad++;
            $display("FAIL mid_before got done=%b cyc=%0d need done=0 cyc=2000", bus1.done, run_cyc);
        end
        rst1_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus1.result, bus1.done, bus1.error} !== 42'd0) begin
                n_bad++;
                $display("FAIL mid_reset cyc %0d got %h/%b/%b need 0/0/0", i, bus1.result, bus1.done, bus1.error);
            end
        end
        rst1_n = 1'b1;
        test_default();
    endtask

    initial begin
        test_reset();
        test_carry_prefix();
        test_short_stream();
        test_error();
        test_default();
        test_hold();
        test_midrun_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
